// File: rtl/neighbor_fetch.sv
// neighbor_fetch: fetches the four orthogonal neighbours of a board cell from a
// 1-cycle-latency board memory, then asks an external checker which tile types
// are legal for that cell and returns the checker's answer as a response.
//
// Sequence per request: IDLE -> RD_UP -> RD_DOWN -> RD_LEFT -> RD_RIGHT -> DRAIN
// -> CHECK -> (WAIT_END) -> RESP. A cell whose four neighbours are all empty is
// "isolated": the checker is skipped and every tile type is reported legal.
//
// Ports:
//   clock, reset           single rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready    request handshake; req_x/req_y give the target cell
//   mem_rd_en/mem_addr     board read port; mem_rd_data returns one cycle later
//   up/down/left/right_tile neighbour codes shown to the checker (0 = empty)
//   start_signal           one-cycle pulse that starts the checker
//   endsignal, tile_type   checker completion and its legal-tile mask
//   rsp_valid/rsp_ready    response handshake
//   rsp_mask               legal-tile mask (6'h3F when isolated, 0 on timeout)
//   rsp_iso                neighbours were all empty, checker skipped
//   rsp_bad                a neighbour read returned the invalid code 7
//   rsp_timeout            checker did not finish in time
//
// Build option: define NEIGHBOR_FETCH_TIMEOUT_EN to bound the checker wait to
// TIMEOUT_CYCLES cycles. Without it the block waits for endsignal indefinitely
// and rsp_timeout is tied low.

module neighbor_fetch #(
  parameter int unsigned BOARD_W        = 8,
  parameter int unsigned BOARD_H        = 8,
  parameter int unsigned COORD_W        = 3,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [2:0]         mem_rd_data,
  output logic [2:0]         up_tile,
  output logic [2:0]         down_tile,
  output logic [2:0]         left_tile,
  output logic [2:0]         right_tile,
  output logic               start_signal,
  input  logic               endsignal,
  input  logic [5:0]         tile_type,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [5:0]         rsp_mask,
  output logic               rsp_iso,
  output logic               rsp_bad,
  output logic               rsp_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("neighbor_fetch: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [3:0] {
    StIdle,
    StRdUp,
    StRdDown,
    StRdLeft,
    StRdRight,
    StDrain,
    StCheck,
    StWaitEnd,
    StResp
  } state_e;

  // Neighbour coordinates carry one extra bit so that x-1 / y-1 at the board
  // edge wraps to a large value and fails the upper-bound test.
  localparam logic [COORD_W:0]  CoordOne = (COORD_W + 1)'(1);
  localparam logic [COORD_W:0]  BoardWc  = (COORD_W + 1)'(BOARD_W);
  localparam logic [COORD_W:0]  BoardHc  = (COORD_W + 1)'(BOARD_H);
  localparam logic [ADDR_W-1:0] BoardWa  = ADDR_W'(BOARD_W);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]         up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic               rd_vld_q;
  logic               bad_q, bad_d;
  logic               iso_q, iso_d;
  logic [5:0]         mask_q, mask_d;

  logic               accept;
  logic               all_empty;
  logic               nb_is_rd;
  logic               nb_in;
  logic [COORD_W:0]   nb_x, nb_y;
  logic [ADDR_W-1:0]  nb_addr;
  logic [2:0]         rd_code;
  logic               rd_bad;

`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;
  assign all_empty = (up_q == 3'd0) && (down_q == 3'd0) && (left_q == 3'd0) && (right_q == 3'd0);

  // Neighbour addressed in the current read state.
  always_comb begin
    nb_x     = {1'b0, x_q};
    nb_y     = {1'b0, y_q};
    nb_is_rd = 1'b0;
    case (state_q)
      StRdUp: begin
        nb_y     = {1'b0, y_q} - CoordOne;
        nb_is_rd = 1'b1;
      end
      StRdDown: begin
        nb_y     = {1'b0, y_q} + CoordOne;
        nb_is_rd = 1'b1;
      end
      StRdLeft: begin
        nb_x     = {1'b0, x_q} - CoordOne;
        nb_is_rd = 1'b1;
      end
      StRdRight: begin
        nb_x     = {1'b0, x_q} + CoordOne;
        nb_is_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign nb_in     = (nb_x < BoardWc) && (nb_y < BoardHc);
  assign nb_addr   = ADDR_W'(nb_y) * BoardWa + ADDR_W'(nb_x);
  assign mem_rd_en = nb_is_rd && nb_in;
  assign mem_addr  = mem_rd_en ? nb_addr : '0;

  // Data returned for last cycle's read; a suppressed read or code 7 reads as empty.
  assign rd_bad  = rd_vld_q && (mem_rd_data == 3'd7);
  assign rd_code = (rd_vld_q && !rd_bad) ? mem_rd_data : 3'd0;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    up_d    = up_q;
    down_d  = down_q;
    left_d  = left_q;
    right_d = right_q;
    bad_d   = bad_q;
    iso_d   = iso_q;
    mask_d  = mask_q;
`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRdUp;
          x_d     = req_x;
          y_d     = req_y;
          up_d    = 3'd0;
          down_d  = 3'd0;
          left_d  = 3'd0;
          right_d = 3'd0;
          bad_d   = 1'b0;
          iso_d   = 1'b0;
          mask_d  = 6'd0;
`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      StRdUp:    state_d = StRdDown;
      StRdDown: begin
        state_d = StRdLeft;
        up_d    = rd_code;
      end
      StRdLeft: begin
        state_d = StRdRight;
        down_d  = rd_code;
      end
      StRdRight: begin
        state_d = StDrain;
        left_d  = rd_code;
      end
      StDrain: begin
        state_d = StCheck;
        right_d = rd_code;
      end
      StCheck: begin
        if (all_empty) begin
          state_d = StResp;
          mask_d  = 6'h3F;
          iso_d   = 1'b1;
        end else begin
          state_d = StWaitEnd;
`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWaitEnd: begin
        if (endsignal) begin
          state_d = StResp;
          mask_d  = tile_type;
        end
`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          state_d = StResp;
          mask_d  = 6'd0;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Sticky for the whole request; cleared on acceptance above.
    if (rd_bad) bad_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      up_q     <= 3'd0;
      down_q   <= 3'd0;
      left_q   <= 3'd0;
      right_q  <= 3'd0;
      rd_vld_q <= 1'b0;
      bad_q    <= 1'b0;
      iso_q    <= 1'b0;
      mask_q   <= 6'd0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      up_q     <= up_d;
      down_q   <= down_d;
      left_q   <= left_d;
      right_q  <= right_d;
      rd_vld_q <= mem_rd_en;
      bad_q    <= bad_d;
      iso_q    <= iso_d;
      mask_q   <= mask_d;
    end
  end

`ifdef NEIGHBOR_FETCH_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign start_signal = (state_q == StCheck) && !all_empty;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_mask     = mask_q;
  assign rsp_iso      = iso_q;
  assign rsp_bad      = bad_q;
  assign up_tile      = up_q;
  assign down_tile    = down_q;
  assign left_tile    = left_q;
  assign right_tile   = right_q;

endmodule
